// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared FSM state encoding, frame constants and baud divisor
//            helper for the buffered UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    typedef logic [2:0] tx_state_t;

    localparam tx_state_t c_st_idle   = 3'd0;
    localparam tx_state_t c_st_start  = 3'd1;
    localparam tx_state_t c_st_data   = 3'd2;
    localparam tx_state_t c_st_parity = 3'd3;
    localparam tx_state_t c_st_stop   = 3'd4;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    // Clocks per line bit; truncating division, so the real rate is slightly fast.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Brief    : Synchronous byte FIFO with first-word fall-through read data,
//            full/empty flags and occupancy count.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [7:0]               wr_data,
    input  logic                     rd_en,
    output logic [7:0]               rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    generate
        if ((DEPTH < 2) || (DEPTH > 256) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_depth_check
            $error("uart_tx_fifo: DEPTH must be a power of two in 2..256");
        end
    endgenerate

    logic [7:0]      r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr;
    logic [c_aw-1:0] r_rd_ptr;
    logic [c_cw-1:0] r_count;
    logic            w_push;
    logic            w_pop;

    // Full is judged on the registered count, so a pop in the same cycle
    // never makes room for a write.
    assign full    = (r_count == c_cw'(DEPTH));
    assign empty   = (r_count == '0);
    assign count   = r_count;
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_aw'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cw'(1);
                2'b01:   r_count <= r_count - c_cw'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffered
// Brief    : FIFO-buffered UART transmitter, 8N1 LSB first. Define
//            UART_TX_PARITY_EN to insert an even parity bit before stop.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffered
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    output logic                          full,
    output logic                          empty,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          busy,
    output logic                          tx_pin_out
);

    localparam int c_div   = calc_div(CLK_FREQ, BAUD);
    localparam int c_cnt_w = (c_div > 2) ? $clog2(c_div) : 1;
    localparam int c_idx_w = $clog2(DATA_BITS);

    generate
        if (c_div < 2) begin : g_div_check
            $error("uart_tx_buffered: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    tx_state_t            r_state;
    logic [c_cnt_w-1:0]   r_baud_cnt;
    logic [c_idx_w-1:0]   r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_tx;
    logic                 r_overflow;
    logic                 w_pop;
    logic                 w_bit_done;
    logic [7:0]           w_fifo_data;

    uart_tx_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (w_pop),
        .rd_data (w_fifo_data),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign w_pop      = (r_state == c_st_idle) && !empty;
    assign w_bit_done = (r_baud_cnt == c_cnt_w'(c_div - 1));
    assign busy       = (r_state != c_st_idle);
    assign tx_pin_out = r_tx;
    assign overflow   = r_overflow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (wr_en && full) begin
            r_overflow <= 1'b1;
        end
    end

    // Counter restarts on every bit boundary and is held at zero while idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_baud_cnt <= '0;
        end else if ((r_state == c_st_idle) || w_bit_done) begin
            r_baud_cnt <= '0;
        end else begin
            r_baud_cnt <= r_baud_cnt + c_cnt_w'(1);
        end
    end

`ifdef UART_TX_PARITY_EN
    logic r_parity;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_fifo_data;
        end
    end
`endif

    // The line is driven from r_tx, so each state loads the level of the
    // next bit on the edge that leaves it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= IDLE_LEVEL;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_pop) begin
                        r_shift <= w_fifo_data;
                        r_state <= c_st_start;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx    <= IDLE_LEVEL;
                    end
                end
                c_st_start: begin
                    if (w_bit_done) begin
                        r_bit_idx <= '0;
                        r_state   <= c_st_data;
                        r_tx      <= r_shift[0];
                    end
                end
                c_st_data: begin
                    if (w_bit_done) begin
                        if (r_bit_idx == c_idx_w'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= c_st_parity;
                            r_tx    <= r_parity;
`else
                            r_state <= c_st_stop;
                            r_tx    <= STOP_LEVEL;
`endif
                        end else begin
                            r_shift   <= {1'b0, r_shift[DATA_BITS-1:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + c_idx_w'(1);
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                c_st_parity: begin
                    if (w_bit_done) begin
                        r_state <= c_st_stop;
                        r_tx    <= STOP_LEVEL;
                    end
                end
`endif
                c_st_stop: begin
                    if (w_bit_done) begin
                        r_state <= c_st_idle;
                        r_tx    <= IDLE_LEVEL;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_tx    <= IDLE_LEVEL;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffered.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffered
// Brief    : Self-checking bench for uart_tx_buffered with a frame-timeline
//            reference model and an independent line decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffered;

    localparam int CLK_FREQ = 1000;
    localparam int BAUD     = 100;
    localparam int DEPTH    = 4;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int CW       = $clog2(DEPTH) + 1;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS      = 11;
    localparam int EXP_PERIOD = 111;
`else
    localparam int NBITS      = 10;
    localparam int EXP_PERIOD = 101;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_data = 8'h00;
    logic          full, empty, overflow, busy, tx_pin_out;
    logic [CW-1:0] fifo_count;

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;

    uart_tx_buffered #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .full       (full),
        .empty      (empty),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .busy       (busy),
        .tx_pin_out (tx_pin_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, ecnt);
    endtask

    // Reference model: a byte queue plus a frame timeline (position within
    // the current frame), not a state machine.
    byte unsigned m_q[$];
    byte unsigned m_sent[$];
    bit           m_ovf = 1'b0;
    bit           m_in_frame = 1'b0;
    int           m_pos = 0;
    bit           m_bits[NBITS];
    int           m_sz;
    bit           m_do_pop;
    byte unsigned m_b;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_sent.delete();
            m_ovf      = 1'b0;
            m_in_frame = 1'b0;
            m_pos      = 0;
        end else begin
            m_sz     = m_q.size();
            m_do_pop = !m_in_frame && (m_sz > 0);
            if (m_in_frame) begin
                m_pos++;
                if (m_pos == NBITS * DIV) m_in_frame = 1'b0;
            end
            if (m_do_pop) begin
                m_b = m_q.pop_front();
                m_bits[0] = 1'b0;
                for (int i = 0; i < 8; i++) m_bits[1 + i] = m_b[i];
`ifdef UART_TX_PARITY_EN
                m_bits[9] = ^m_b;
`endif
                m_bits[NBITS - 1] = 1'b1;
                m_in_frame = 1'b1;
                m_pos      = 0;
                m_sent.push_back(m_b);
            end
            if (wr_en) begin
                if (m_sz < DEPTH) m_q.push_back(wr_data);
                else m_ovf = 1'b1;
            end
        end
    end

    logic [CW+4:0] exp_v;
    logic          e_tx;
    always @(negedge clk) begin
        e_tx  = m_in_frame ? m_bits[m_pos / DIV] : 1'b1;
        exp_v = {e_tx, m_in_frame, (m_q.size() == DEPTH), (m_q.size() == 0), m_ovf, CW'(m_q.size())};
        chk("outputs{tx,busy,full,empty,ovf,count}",
            {tx_pin_out, busy, full, empty, overflow, fifo_count}, exp_v);
    end

    // Independent line decoder sampling mid-bit.
    byte unsigned rx_q[$];
    int           rx_t[$];
    bit           d_busy = 1'b0;
    bit           d_prev = 1'b1;
    int           d_start, d_off, d_j;
    byte unsigned d_byte;

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            d_busy = 1'b0;
            d_prev = 1'b1;
        end else begin
            if (!d_busy) begin
                if (d_prev && !tx_pin_out) begin
                    d_busy  = 1'b1;
                    d_start = ecnt;
                end
            end else begin
                d_off = ecnt - d_start;
                if ((d_off % DIV) == DIV / 2) begin
                    d_j = d_off / DIV;
                    if (d_j == 0) begin
                        chk("rx_start_bit", tx_pin_out, 0);
                    end else if (d_j <= 8) begin
                        d_byte[d_j - 1] = tx_pin_out;
`ifdef UART_TX_PARITY_EN
                    end else if (d_j == 9) begin
                        chk("rx_parity_bit", tx_pin_out, ^d_byte);
`endif
                    end else begin
                        chk("rx_stop_bit", tx_pin_out, 1);
                        rx_q.push_back(d_byte);
                        rx_t.push_back(d_start);
                        if (m_sent.size() == 0) chk("rx_unexpected_frame", d_byte, 'h100);
                        else chk("rx_byte_vs_model", d_byte, m_sent.pop_front());
                        d_busy = 1'b0;
                    end
                end
            end
            d_prev = tx_pin_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycle(input int c);
        while (ecnt < c) step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int k = 0;
        while (rx_q.size() < n && k < budget) begin
            step();
            k++;
        end
        chk("rx_frame_count", rx_q.size(), n);
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_t.delete();
    endtask

    int  n0, peak, k;
    bit  a5_bits[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    int  pcts[6]    = '{2, 8, 40, 1, 15, 0};

    initial begin
        #1 rst = 1'b1;
        @(negedge clk); #1;
        chk("reset_state{tx,busy,full,empty,ovf,count}",
            {tx_pin_out, busy, full, empty, overflow, fifo_count}, {5'b10010, CW'(0)});
        step(); step();
        rst = 1'b0;

        // Idle line after reset.
        for (int i = 0; i < 50; i++) begin
            step();
            chk("idle{tx,busy,empty}", {tx_pin_out, busy, empty}, 3'b101);
        end

        // Single 0xA5 frame with literal timing.
        clear_rx();
        n0 = ecnt;
        wr_en = 1'b1; wr_data = 8'hA5; step(); wr_en = 1'b0;
        wait_cycle(n0 + 1);
        chk("a5_empty_n1", empty, 0);
        chk("a5_busy_n1", busy, 0);
        chk("a5_tx_n1", tx_pin_out, 1);
        wait_cycle(n0 + 2);
        chk("a5_start_first", tx_pin_out, 0);
        wait_cycle(n0 + 11);
        chk("a5_start_last", tx_pin_out, 0);
        for (int i = 0; i < 8; i++) begin
            wait_cycle(n0 + 12 + DIV * i);
            chk("a5_data_bit_first", tx_pin_out, a5_bits[i]);
            wait_cycle(n0 + 12 + DIV * i + DIV - 1);
            chk("a5_data_bit_last", tx_pin_out, a5_bits[i]);
        end
`ifdef UART_TX_PARITY_EN
        wait_cycle(n0 + 97);
        chk("a5_parity", tx_pin_out, 0);
`endif
        wait_cycle(n0 + 2 + (NBITS - 1) * DIV);
        chk("a5_stop_first", tx_pin_out, 1);
        wait_cycle(n0 + 1 + NBITS * DIV);
        chk("a5_stop_last_tx", tx_pin_out, 1);
        chk("a5_stop_last_busy", busy, 1);
        wait_cycle(n0 + 2 + NBITS * DIV);
        chk("a5_busy_fall", busy, 0);
        wait_rx(1, 20);
        if (rx_q.size() > 0) chk("a5_decoded", rx_q[0], 8'hA5);
        step();

        // Three back-to-back bytes.
        clear_rx();
        wr_en = 1'b1;
        wr_data = 8'h00; step();
        wr_data = 8'hFF; step();
        wr_data = 8'h3C; step();
        wr_en = 1'b0;
        peak = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            if (int'(fifo_count) > peak) peak = int'(fifo_count);
        end
        chk("b2b_peak_count", peak, 2);
        wait_rx(3, 4 * EXP_PERIOD);
        if (rx_q.size() == 3) begin
            chk("b2b_byte0", rx_q[0], 8'h00);
            chk("b2b_byte1", rx_q[1], 8'hFF);
            chk("b2b_byte2", rx_q[2], 8'h3C);
            chk("b2b_period01", rx_t[1] - rx_t[0], EXP_PERIOD);
            chk("b2b_period12", rx_t[2] - rx_t[1], EXP_PERIOD);
        end
        repeat (DIV) step();

        // Overflow: six consecutive writes into a depth-4 FIFO.
        clear_rx();
        wr_en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            wr_data = 8'(8'h11 * i);
            step();
        end
        wr_en = 1'b0;
        @(negedge clk); #1;
        chk("ovf_full", full, 1);
        chk("ovf_count", fifo_count, 4);
        chk("ovf_flag", overflow, 1);
        wait_rx(5, 6 * EXP_PERIOD);
        if (rx_q.size() >= 5) begin
            for (int i = 0; i < 5; i++) chk("ovf_byte", rx_q[i], 8'(8'h11 * (i + 1)));
        end
        repeat (EXP_PERIOD + 10) step();
        chk("ovf_frames_total", rx_q.size(), 5);
        chk("ovf_sticky", overflow, 1);

        // Randomised traffic, checked every cycle by the model.
        for (int p = 0; p < 6; p++) begin
            for (int i = 0; i < 500; i++) begin
                wr_en   = ($urandom_range(0, 99) < pcts[p]);
                wr_data = 8'($urandom);
                step();
            end
        end
        wr_en = 1'b0;
        k = 0;
        while ((m_q.size() != 0 || m_in_frame) && k < (DEPTH + 2) * EXP_PERIOD) begin
            step();
            k++;
        end
        chk("random_drained", (m_q.size() == 0 && !m_in_frame), 1);
        repeat (4) step();

        // Reset in the middle of a frame with bytes still queued.
        clear_rx();
        n0 = ecnt;
        wr_en = 1'b1;
        wr_data = 8'h5A; step();
        wr_data = 8'h01; step();
        wr_data = 8'h02; step();
        wr_data = 8'h03; step();
        wr_en = 1'b0;
        wait_cycle(n0 + 2 + 35);
        chk("rst_pre_tx_bit2", tx_pin_out, 0);
        chk("rst_pre_count", fifo_count, 3);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_tx", tx_pin_out, 1);
        chk("rst_mid_count", fifo_count, 0);
        chk("rst_mid_overflow", overflow, 0);
        chk("rst_mid_busy", busy, 0);
        step(); step();
        rst = 1'b0;
        repeat (3 * EXP_PERIOD) step();
        chk("rst_no_frames", rx_q.size(), 0);
        chk("rst_line_idle", tx_pin_out, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
`default_nettype wire
